decode_ui: RTL and testbench

Morse-key decode and UI controller. It collects dit/dah key events into a symbol buffer and translates a completed symbol group into an ASCII character after a silence gap. Characters are appended to a 16-character LCD line buffer. It also drives piezo sidetone, LEDs, error flag and key-mode requests. It sits between the key mapper (key_mapped/key_valid/key_pressed) and the LCD/piezo/LED drivers.

---
 rtl/decode_ui.sv | 172 +++++++++++++++++
 tb/tb_decode_ui.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ui.sv
// decode_ui: Morse key decoder feeding a 16-character LCD line buffer.
// Also drives the piezo sidetone/error beep, the LEDs and key-mode requests.
module decode_ui #(
  parameter logic [2:0] VERSION = 3'd1,
  parameter int         TONE_HZ = 800,
  parameter int         ERR_HZ  = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] key_mapped,
  input  logic        key_valid,
  input  logic        key_pressed,
  input  logic [31:0] dit_gap_lim,
  output logic [1:0]  req_key_mode,
  output logic        req_mode_change,
  output logic [7:0]  lcd_char_out,
  input  logic [3:0]  lcd_query_addr,
  output logic        piezo_enable,
  output logic [31:0] piezo_freq,
  output logic [7:0]  led_out,
  output logic        is_error,
  output logic [2:0]  ui_version
);
  typedef enum logic {INPUT, TRANS} state_t;
  state_t      state_q, state_d;
  logic [2:0]  len_q, len_d;
  logic [4:0]  bits_q, bits_d;
  logic [31:0] sil_q, sil_d, beep_q, beep_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  obuf_q [16];
  logic [7:0]  obuf_d [16];
  logic        err_q, err_d, tone_q, tone_d, chg_q, chg_d;
  logic [1:0]  mode_q, mode_d;
  logic        app;
  logic [7:0]  app_ch, ch;
  logic [2:0]  typ;
  logic [3:0]  bs_a;
  logic        unused_ok;

  // ITU code lookup; first symbol is the MSB of the len-bit group, 0 = miss
  function automatic logic [7:0] itu(input logic [2:0] len, input logic [4:0] bits);
    case ({len, bits})
      8'b001_00000: itu = "E";  8'b001_00001: itu = "T";
      8'b010_00000: itu = "I";  8'b010_00001: itu = "A";
      8'b010_00010: itu = "N";  8'b010_00011: itu = "M";
      8'b011_00000: itu = "S";  8'b011_00001: itu = "U";
      8'b011_00010: itu = "R";  8'b011_00011: itu = "W";
      8'b011_00100: itu = "D";  8'b011_00101: itu = "K";
      8'b011_00110: itu = "G";  8'b011_00111: itu = "O";
      8'b100_00000: itu = "H";  8'b100_00001: itu = "V";
      8'b100_00010: itu = "F";  8'b100_00100: itu = "L";
      8'b100_00110: itu = "P";  8'b100_00111: itu = "J";
      8'b100_01000: itu = "B";  8'b100_01001: itu = "X";
      8'b100_01010: itu = "C";  8'b100_01011: itu = "Y";
      8'b100_01100: itu = "Z";  8'b100_01101: itu = "Q";
      8'b101_00000: itu = "5";  8'b101_00001: itu = "4";
      8'b101_00011: itu = "3";  8'b101_00111: itu = "2";
      8'b101_01111: itu = "1";  8'b101_10000: itu = "6";
      8'b101_11000: itu = "7";  8'b101_11100: itu = "8";
      8'b101_11110: itu = "9";  8'b101_11111: itu = "0";
      default:      itu = 8'h00;
    endcase
  endfunction

  assign typ       = key_mapped[10:8];
  assign unused_ok = &{1'b0, key_mapped[7:0]};
  assign ch        = itu(len_q, bits_q);
  assign bs_a      = idx_q[3:0] - 4'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bits_d  = bits_q;
    idx_d   = idx_q;
    obuf_d  = obuf_q;
    err_d   = err_q;
    tone_d  = tone_q;
    mode_d  = mode_q;
    chg_d   = 1'b0;
    app     = 1'b0;
    app_ch  = 8'h20;
    sil_d   = (key_pressed || key_valid || len_q == 3'd0) ? 32'd0 :
              (sil_q != '1) ? sil_q + 32'd1 : sil_q;
    beep_d  = (beep_q != 32'd0) ? beep_q - 32'd1 : 32'd0;
    if (state_q == TRANS) begin
      app     = 1'b1;
      app_ch  = (ch != 8'h00) ? ch : "?";
      err_d   = (ch == 8'h00);
      beep_d  = (ch == 8'h00) ? dit_gap_lim : beep_d;
      len_d   = 3'd0;
      bits_d  = 5'd0;
      sil_d   = 32'd0;
      state_d = INPUT;
    end else if (key_valid) begin
      tone_d = (typ[2:1] == 2'b00);
      if (typ[2:1] == 2'b00) begin
        err_d  = (len_q == 3'd5) ? 1'b1 : err_q;
        beep_d = (len_q == 3'd5) ? dit_gap_lim : beep_d;
        len_d  = (len_q == 3'd5) ? 3'd0 : len_q + 3'd1;
        bits_d = (len_q == 3'd5) ? 5'd0 : {bits_q[3:0], typ[0]};
      end else if (typ == 3'b010) begin
        app = 1'b1;
      end else if (typ == 3'b011) begin
        len_d  = 3'd0;
        bits_d = 5'd0;
        if (idx_q != 5'd0) begin
          idx_d        = idx_q - 5'd1;
          obuf_d[bs_a] = 8'h20;
        end
      end else if (typ == 3'b100) begin
        for (int i = 0; i < 16; i++) obuf_d[i] = 8'h20;
        idx_d  = 5'd0;
        err_d  = 1'b0;
        len_d  = 3'd0;
        bits_d = 5'd0;
      end else if (typ == 3'b101) begin
        mode_d = ~mode_q;
        chg_d  = 1'b1;
      end
    end else if (len_q != 3'd0 && sil_q == dit_gap_lim) begin
      state_d = TRANS;
    end
    // A full line scrolls left so the newest character always lands at 15
    if (app) begin
      if (idx_q == 5'd16) begin
        for (int i = 0; i < 15; i++) obuf_d[i] = obuf_q[i+1];
        obuf_d[15] = app_ch;
      end else begin
        obuf_d[idx_q[3:0]] = app_ch;
        idx_d              = idx_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INPUT;
      len_q   <= 3'd0;
      bits_q  <= 5'd0;
      sil_q   <= 32'd0;
      beep_q  <= 32'd0;
      idx_q   <= 5'd0;
      for (int i = 0; i < 16; i++) obuf_q[i] <= 8'h20;
      err_q   <= 1'b0;
      tone_q  <= 1'b0;
      mode_q  <= 2'b01;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bits_q  <= bits_d;
      sil_q   <= sil_d;
      beep_q  <= beep_d;
      idx_q   <= idx_d;
      obuf_q  <= obuf_d;
      err_q   <= err_d;
      tone_q  <= tone_d;
      mode_q  <= mode_d;
      chg_q   <= chg_d;
    end
  end

  assign req_key_mode    = mode_q;
  assign req_mode_change = chg_q;
  assign lcd_char_out    = obuf_q[lcd_query_addr];
  assign led_out         = {len_q, bits_q};
  assign is_error        = err_q;
  assign ui_version      = VERSION;
  assign piezo_enable    = (beep_q != 32'd0) || (key_pressed && tone_q);
  assign piezo_freq      = (beep_q != 32'd0) ? 32'(ERR_HZ) :
                           (key_pressed && tone_q) ? 32'(TONE_HZ) : 32'd0;
endmodule

// File: tb/tb_decode_ui.sv
// tb_decode_ui: directed table-driven checks of Morse decoding, the LCD line
// buffer, piezo behaviour, mode requests and reset.
module tb_decode_ui;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] key_mapped = '0;
  logic        key_valid = 1'b0;
  logic        key_pressed = 1'b0;
  logic [31:0] lim = 32'd10000;
  logic [1:0]  req_key_mode;
  logic        req_mode_change;
  logic [7:0]  lcd_char_out;
  logic [3:0]  lcd_query_addr = '0;
  logic        piezo_enable;
  logic [31:0] piezo_freq;
  logic [7:0]  led_out;
  logic        is_error;
  logic [2:0]  ui_version;
  int          nv = 0;
  int          ne = 0;

  typedef struct {
    string      name;
    int         len;
    logic [4:0] bits;
    logic [7:0] ch;
    logic       err;
  } vec_t;
  vec_t vt [14];

  decode_ui dut (
    .clk(clk), .rst_n(rst_n), .key_mapped(key_mapped), .key_valid(key_valid),
    .key_pressed(key_pressed), .dit_gap_lim(lim), .req_key_mode(req_key_mode),
    .req_mode_change(req_mode_change), .lcd_char_out(lcd_char_out),
    .lcd_query_addr(lcd_query_addr), .piezo_enable(piezo_enable),
    .piezo_freq(piezo_freq), .led_out(led_out), .is_error(is_error),
    .ui_version(ui_version)
  );

  always #50 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    nv++;
    if (got !== exp) begin
      ne++;
      $display("FAIL %s: got %0h, expected %0h", n, got, exp);
    end
  endtask

  task automatic chk_lcd(input string n, input int a, input logic [7:0] exp);
    lcd_query_addr = a[3:0];
    #1;
    chk(n, {24'd0, lcd_char_out}, {24'd0, exp});
  endtask

  task automatic key(input logic [2:0] t);
    key_mapped = {t, 8'h00};
    key_valid  = 1'b1;
    tick;
    key_valid  = 1'b0;
  endtask

  task automatic sym(input logic s, input int hold);
    key_pressed = 1'b1;
    key_mapped  = {2'b00, s, 8'h00};
    key_valid   = 1'b1;
    tick;
    key_valid   = 1'b0;
    repeat (hold - 1) tick;
    key_pressed = 1'b0;
  endtask

  task automatic send_char(input int len, input logic [4:0] bits);
    for (int s = len - 1; s >= 0; s--) begin
      sym(bits[s], 1);
      tick;
    end
    repeat (lim + 1) tick;
  endtask

  initial begin
    vt[0]  = '{"E", 1, 5'b00000, "E", 1'b0};
    vt[1]  = '{"T", 1, 5'b00001, "T", 1'b0};
    vt[2]  = '{"A", 2, 5'b00001, "A", 1'b0};
    vt[3]  = '{"M", 2, 5'b00011, "M", 1'b0};
    vt[4]  = '{"K", 3, 5'b00101, "K", 1'b0};
    vt[5]  = '{"H", 4, 5'b00000, "H", 1'b0};
    vt[6]  = '{"Q", 4, 5'b01101, "Q", 1'b0};
    vt[7]  = '{"Z", 4, 5'b01100, "Z", 1'b0};
    vt[8]  = '{"J", 4, 5'b00111, "J", 1'b0};
    vt[9]  = '{"0", 5, 5'b11111, "0", 1'b0};
    vt[10] = '{"5", 5, 5'b00000, "5", 1'b0};
    vt[11] = '{"9", 5, 5'b11110, "9", 1'b0};
    vt[12] = '{"miss4", 4, 5'b00011, "?", 1'b1};
    vt[13] = '{"miss5", 5, 5'b01010, "?", 1'b1};

    repeat (10) tick;
    for (int a = 0; a < 16; a++) chk_lcd("rst_lcd", a, 8'h20);
    chk("rst_ver", {29'd0, ui_version}, 32'd1);
    chk("rst_mode", {30'd0, req_key_mode}, 32'd1);
    chk("rst_led", {24'd0, led_out}, 32'd0);
    chk("rst_pz", {31'd0, piezo_enable}, 32'd0);
    chk("rst_err", {31'd0, is_error}, 32'd0);
    rst_n = 1'b1;
    tick;

    sym(1'b0, 10000);
    repeat (5000) tick;
    chk("gap_led", {24'd0, led_out}, 32'h20);
    chk_lcd("gap_lcd", 0, 8'h20);
    key_pressed = 1'b1;
    key_mapped  = {3'b001, 8'h00};
    key_valid   = 1'b1;
    tick;
    key_valid   = 1'b0;
    chk("dah_pz_en", {31'd0, piezo_enable}, 32'd1);
    chk("dah_pz_f", piezo_freq, 32'd800);
    repeat (29999) tick;
    key_pressed = 1'b0;
    chk("dah_led", {24'd0, led_out}, 32'h41);
    repeat (10001) tick;
    chk_lcd("trans_lcd", 0, 8'h20);
    chk("trans_led", {24'd0, led_out}, 32'h41);
    tick;
    chk_lcd("A_lcd", 0, "A");
    chk("A_led", {24'd0, led_out}, 32'd0);
    chk("A_err", {31'd0, is_error}, 32'd0);
    chk("A_pz", {31'd0, piezo_enable}, 32'd0);

    lim = 32'd8;
    for (int v = 0; v < 14; v++) begin
      key(3'b100);
      send_char(vt[v].len, vt[v].bits);
      chk_lcd({vt[v].name, "_ch"}, 0, vt[v].ch);
      chk({vt[v].name, "_err"}, {31'd0, is_error}, {31'd0, vt[v].err});
      chk({vt[v].name, "_led"}, {24'd0, led_out}, 32'd0);
    end

    key(3'b100);
    repeat (lim + 2) tick;
    key_pressed = 1'b1;
    key_mapped  = {3'b000, 8'h00};
    key_valid   = 1'b1;
    tick;
    key_valid   = 1'b0;
    chk("E_pz_en", {31'd0, piezo_enable}, 32'd1);
    chk("E_pz_f", piezo_freq, 32'd800);
    tick;
    chk("E_pz_hold", piezo_freq, 32'd800);
    key_pressed = 1'b0;
    tick;
    chk("E_pz_off", {31'd0, piezo_enable}, 32'd0);
    chk("E_pz_f0", piezo_freq, 32'd0);
    repeat (lim + 2) tick;
    chk_lcd("E_lcd", 0, "E");

    key(3'b100);
    for (int i = 0; i < 4; i++) begin sym(1'b1, 1); tick; end
    sym(1'b0, 1);
    tick;
    key_pressed = 1'b1;
    key_mapped  = {3'b001, 8'h00};
    key_valid   = 1'b1;
    tick;
    key_valid   = 1'b0;
    chk("six_err", {31'd0, is_error}, 32'd1);
    chk("six_led", {24'd0, led_out}, 32'd0);
    chk("six_pz_f", piezo_freq, 32'd200);
    chk("six_pz_en", {31'd0, piezo_enable}, 32'd1);
    key_pressed = 1'b0;
    repeat (lim + 4) tick;
    chk_lcd("six_lcd", 0, 8'h20);
    chk("beep_end", {31'd0, piezo_enable}, 32'd0);
    send_char(1, 5'b00000);
    chk_lcd("six_next", 0, "E");
    chk("six_clr_err", {31'd0, is_error}, 32'd0);

    key(3'b100);
    send_char(1, 5'b00001);
    for (int i = 0; i < 15; i++) send_char(1, 5'b00000);
    chk_lcd("full_0", 0, "T");
    chk_lcd("full_15", 15, "E");
    send_char(1, 5'b00000);
    chk_lcd("shift_0", 0, "E");
    chk_lcd("shift_15", 15, "E");
    key(3'b010);
    chk_lcd("sp_14", 14, "E");
    chk_lcd("sp_15", 15, 8'h20);
    key(3'b011);
    send_char(1, 5'b00001);
    chk_lcd("bs_14", 14, "E");
    chk_lcd("bs_15", 15, "T");

    key(3'b101);
    chk("mode_pulse", {31'd0, req_mode_change}, 32'd1);
    chk("mode_req", {30'd0, req_key_mode}, 32'd2);
    tick;
    chk("mode_pulse_end", {31'd0, req_mode_change}, 32'd0);
    key(3'b101);
    chk("mode_back", {30'd0, req_key_mode}, 32'd1);
    key(3'b100);
    chk_lcd("clr_0", 0, 8'h20);
    chk_lcd("clr_7", 7, 8'h20);
    chk_lcd("clr_15", 15, 8'h20);
    key(3'b011);
    send_char(1, 5'b00001);
    chk_lcd("bs0_0", 0, "T");
    chk_lcd("bs0_1", 1, 8'h20);

    sym(1'b1, 1);
    tick;
    chk("pre_rst_led", {24'd0, led_out}, 32'h21);
    #20 rst_n = 1'b0;
    #1;
    chk("mid_rst_led", {24'd0, led_out}, 32'd0);
    chk_lcd("mid_rst_lcd", 0, 8'h20);
    tick;
    rst_n = 1'b1;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", nv, ne);
    $finish;
  end
endmodule
